// File: rtl/nibble_pkg.sv
// Shared constants, word types and parity helper for the nibble packer.
package nibble_pkg;
  localparam int NIBBLE_W       = 4;
  localparam int DEF_NIBBLES    = 4;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_DROP_W     = 8;
  localparam int DEF_DATA_W     = NIBBLE_W * DEF_NIBBLES;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef struct packed {
    logic  parity;
    word_t word;
  } pword_t;

  // Even parity over a word zero-extended to 64 bits.
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/packer_fifo.sv
// Small synchronous FIFO for completed words; head entry read straight from storage regs.
module packer_fifo
  import nibble_pkg::*;
#(
  parameter int W     = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             cnt_q;
  logic                    do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so push is allowed even when full.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/nibble_packer.sv
// Packs upstream nibbles LSB-first into parity-tagged words; drops and counts
// nibbles it cannot take since the upstream has no backpressure.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int NIBBLES    = DEF_NIBBLES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DROP_W     = DEF_DROP_W,
  localparam int DATA_W    = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NIBBLE_W-1:0] d_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [DATA_W-1:0]   d_out,
  output logic                out_parity,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DROP_W-1:0]   drop_cnt,
  input  logic                test_mode,
  input  logic                scan_en,
  input  logic                scan_in0,
  output logic                scan_out0
);
  localparam int PH_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              last, accept, push, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_din, fifo_dout;
  logic              unused_dft;

  assign last      = (phase_q == PH_W'(NIBBLES-1));
  assign in_ready  = !(last && fifo_full);
  assign accept    = in_valid && in_ready;
  assign fifo_din  = {parity(64'(shift_d)), shift_d};
  assign drop_cnt  = drop_q;
  assign scan_out0 = 1'b0;
  assign unused_dft = ^{test_mode, scan_en, scan_in0};

  always_comb begin
    phase_d = phase_q;
    shift_d = shift_q;
    drop_d  = drop_q;
    push    = 1'b0;
    if (in_valid && !in_ready && drop_q != '1) drop_d = drop_q + 1'b1;
    // Flush wins over a same-cycle accept; that nibble is silently discarded.
    if (flush) begin
      phase_d = '0;
      shift_d = '0;
    end else if (accept) begin
      shift_d[phase_q*NIBBLE_W +: NIBBLE_W] = d_in;
      push    = last;
      phase_d = last ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      shift_q <= '0;
      drop_q  <= '0;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
      drop_q  <= drop_d;
    end
  end

  packer_fifo #(.W(DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (out_ready),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign d_out      = fifo_dout[DATA_W-1:0];
  assign out_parity = fifo_dout[DATA_W];
  assign out_valid  = !fifo_empty;
endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench: directed vector table, corner sequences, random run vs queue model.
module tb_nibble_packer;
  logic        clk = 1'b0, reset = 1'b0;
  logic [3:0]  d_in = '0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_parity, out_valid, scan_out0;
  logic [15:0] d_out;
  logic [7:0]  drop_cnt;

  int checks = 0, failures = 0;

  nibble_packer dut (
    .clk(clk), .reset(reset), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .d_out(d_out), .out_parity(out_parity), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt), .test_mode(1'b0), .scan_en(1'b0),
    .scan_in0(1'b0), .scan_out0(scan_out0)
  );

  always #5 clk = ~clk;

  // Reference model: nibble slots, a word queue of depth 2, a saturating drop count.
  int          m_phase = 0, m_drop = 0;
  logic [3:0]  m_nib[4];
  logic [15:0] m_q[$];

  function automatic logic m_ready();
    return !(m_phase == 3 && m_q.size() == 2);
  endfunction

  function automatic logic m_par(input logic [15:0] w);
    return 1'($countones(w) % 2);
  endfunction

  function automatic void m_reset();
    m_phase = 0;
    m_drop  = 0;
    m_q.delete();
  endfunction

  function automatic void m_step(input logic v, input logic [3:0] d, input logic fl, input logic ordy);
    logic        rdy = m_ready();
    logic [15:0] w;
    if (ordy && m_q.size() > 0) void'(m_q.pop_front());
    if (v && !rdy && m_drop < 255) m_drop++;
    if (fl) m_phase = 0;
    else if (v && rdy) begin
      m_nib[m_phase] = d;
      if (m_phase == 3) begin
        w = '0;
        for (int k = 0; k < 4; k++) w = w | (16'(m_nib[k]) << (4*k));
        m_q.push_back(w);
        m_phase = 0;
      end else m_phase++;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic fl, input logic ordy);
    in_valid = v; d_in = d; flush = fl; out_ready = ordy;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_step(in_valid, d_in, flush, out_ready);
    #1;
  endtask

  // One model-checked cycle.
  task automatic cyc(input logic v, input logic [3:0] d, input logic fl, input logic ordy);
    drive(v, d, fl, ordy);
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("d_out", 32'(d_out), 32'(m_q[0]));
      chk("out_parity", 32'(out_parity), 32'(m_par(m_q[0])));
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    edge_step();
  endtask

  typedef struct {
    logic v; logic [3:0] d; logic fl; logic ordy;
    logic ev; logic [15:0] ed; logic ep; logic er; logic [7:0] edr;
  } vec_t;
  vec_t tv[22];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // v, d, flush, out_ready | exp valid, d_out, parity, in_ready, drop_cnt (before edge)
    tv = '{
      '{1'b1,4'h1,1'b0,1'b1, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h2,1'b0,1'b1, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h3,1'b0,1'b1, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h4,1'b0,1'b1, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b0,4'h0,1'b0,1'b1, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b0,4'h0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h1,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h2,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h3,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h4,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1,8'd0},
      '{1'b1,4'h5,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'h6,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'h7,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'h8,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'h9,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'hA,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'hB,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b1,8'd0},
      '{1'b1,4'hC,1'b0,1'b0, 1'b1,16'h4321,1'b1,1'b0,8'd0},
      '{1'b0,4'h0,1'b0,1'b1, 1'b1,16'h4321,1'b1,1'b0,8'd1},
      '{1'b1,4'hD,1'b0,1'b1, 1'b1,16'h8765,1'b0,1'b1,8'd1},
      '{1'b0,4'h0,1'b0,1'b1, 1'b1,16'hDBA9,1'b0,1'b1,8'd1},
      '{1'b0,4'h0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1,8'd1}
    };

    m_reset();
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst d_out", 32'(d_out), 32'd0);
    chk("rst out_parity", 32'(out_parity), 32'd0);
    chk("rst scan_out0", 32'(scan_out0), 32'd0);
    reset = 1'b1;

    // Basic pack and backpressure/drop table.
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].v, tv[i].d, tv[i].fl, tv[i].ordy);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tv[i].er));
      chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(tv[i].edr));
      if (tv[i].ev) begin
        chk($sformatf("vec%0d d_out", i), 32'(d_out), 32'(tv[i].ed));
        chk($sformatf("vec%0d parity", i), 32'(out_parity), 32'(tv[i].ep));
      end
      edge_step();
    end

    // Flush mid-word, with a nibble in the flush cycle that must be neither kept nor counted.
    cyc(1'b1, 4'h5, 1'b0, 1'b0);
    cyc(1'b1, 4'h6, 1'b0, 1'b0);
    cyc(1'b1, 4'h9, 1'b1, 1'b0);
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 4'hE, 1'b0, 1'b0);
    cyc(1'b1, 4'hD, 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    chk("flush out_valid", 32'(out_valid), 32'd1);
    chk("flush d_out", 32'(d_out), 32'hCDEF);
    chk("flush parity", 32'(out_parity), 32'd0);
    chk("flush drop_cnt", 32'(drop_cnt), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a word.
    cyc(1'b1, 4'h7, 1'b0, 1'b1);
    cyc(1'b1, 4'h8, 1'b0, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst drop_cnt", 32'(drop_cnt), 32'd0);
    m_reset();
    in_valid = 1'b0;
    #1 reset = 1'b1;
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 1'b0, 1'b0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    cyc(1'b1, 4'h4, 1'b0, 1'b0);
    chk("midrst word", 32'(d_out), 32'h4321);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Saturation: full FIFO, held at last phase, 300 offered nibbles.
    for (int i = 1; i <= 11; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
    chk("sat in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 4'($urandom), 1'b0, 1'b0);
    chk("sat drop_cnt", 32'(drop_cnt), 32'd255);

    // Simultaneous push and pop with one word buffered.
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'hE, 1'b0, 1'b1);
    chk("pushpop out_valid", 32'(out_valid), 32'd1);
    chk("pushpop d_out", 32'(d_out), 32'hEBA9);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("pushpop drained", 32'(out_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
